// File: rtl/conv_stream_ctrl.sv
// -----------------------------------------------------------------------------
// conv_stream_ctrl
//
// AXI4-Stream sequencer wrapped around one CONV_GAUSS instance. It converts the
// input/output valid/ready handshakes into the conv's stall and synchronous
// reset controls. It also hides the conv's one-row output lag. Once the last
// input beat of a frame has been taken, it feeds one row of zero beats into
// the conv so that the last image row is produced. Pixel data only passes
// through the conv; this block never modifies it.
//
// Ports
//   clk           rising-edge clock
//   areset        asynchronous active-high reset
//   s_tdata       input pixels (DATA_WIDTH)
//   s_tvalid      input beat valid
//   s_tready      input beat accepted
//   s_tuser       start of frame, on the first beat
//   s_tlast       end of frame, on beat BPF-1
//   conv_inp      to conv inp_frame: s_tdata while running, zero while flushing
//   conv_stall    to conv stall, high whenever the conv must not advance
//   conv_aresetn  to conv aresetn (synchronous, active-low), low while idle
//   conv_out      from conv out_frame
//   m_tdata       output pixels, equal to conv_out
//   m_tvalid      output beat valid
//   m_tready      downstream ready
//   m_tuser       start of frame, on the first output beat
//   m_tlast       on output beat BPF-1
//   frame_err     one-cycle pulse on a framing (SOF/tlast) violation
//
// Optional build macro CONV_CTRL_STATS_EN adds:
//   frame_cnt     count of m_tlast handshakes (wraps at 2^32)
//   stall_cnt     count of RUN/FLUSH cycles without a conv advance (wraps)
// -----------------------------------------------------------------------------
module conv_stream_ctrl #(
  parameter int  PIXELS_PER_BEAT = 16,
  parameter int  PIXEL_WIDTH     = 8,
  parameter int  IMAGE_DIM       = 512,
  localparam int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] conv_inp,
  output logic                  conv_stall,
  output logic                  conv_aresetn,
  input  logic [DATA_WIDTH-1:0] conv_out,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic                  frame_err
`ifdef CONV_CTRL_STATS_EN
  ,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int BPR = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int BPF = IMAGE_DIM * BPR;
  localparam int CW  = $clog2(BPF + BPR + 1);

  localparam logic [CW-1:0] LAST_RUN_IDX  = CW'(BPF - 1);
  localparam logic [CW-1:0] FIRST_OUT_IDX = CW'(BPR);
  localparam logic [CW-1:0] LAST_ADV_IDX  = CW'(BPF + BPR - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   adv_idx_r;
  logic            alive_r;
  logic            m_tvalid_r;
  logic            m_tuser_r;
  logic            m_tlast_r;
  logic            conv_aresetn_r;
  logic            frame_err_r;
  logic            out_free_s;
  logic            adv_s;
  logic            ready_s;
  logic            err_s;
  logic [DATA_WIDTH-1:0] inp_s;

  // Next-state, conv advance, input ready and framing-error decode.
  always_comb begin
    state_nxt_s = state_r;
    adv_s       = 1'b0;
    ready_s     = 1'b0;
    err_s       = 1'b0;
    inp_s       = '0;
    // The output slot can take a new beat if it is empty or being drained now.
    out_free_s  = ~m_tvalid_r | m_tready;
    case (state_r)
      ST_IDLE: begin
        // alive_r keeps s_tready low until the first clock after reset.
        ready_s = alive_r;
        if (alive_r && s_tvalid) begin
          // An SOF beat stays on the bus and becomes beat 0 in RUN;
          // any other beat is swallowed and flagged.
          if (s_tuser) begin
            state_nxt_s = ST_RUN;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        ready_s = out_free_s;
        inp_s   = s_tdata;
        if (out_free_s && s_tvalid) begin
          adv_s = 1'b1;
          // Framing checks only flag; the beat count is never adjusted.
          err_s = (s_tlast != (adv_idx_r == LAST_RUN_IDX)) |
                  (s_tuser & (adv_idx_r != '0));
          if (adv_idx_r == LAST_RUN_IDX) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Zero row pushed through the conv to release the last image row.
        adv_s = out_free_s;
        if (out_free_s && (adv_idx_r == LAST_ADV_IDX)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (m_tvalid_r && m_tready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, advance counter and registered control outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r        <= ST_IDLE;
      adv_idx_r      <= '0;
      alive_r        <= 1'b0;
      conv_aresetn_r <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      alive_r        <= 1'b1;
      // Taken from the next state so the conv is held in reset for every
      // IDLE cycle and released on the first cycle after leaving IDLE.
      conv_aresetn_r <= (state_nxt_s != ST_IDLE);
      frame_err_r    <= err_s;
      if (state_r == ST_IDLE) begin
        adv_idx_r <= '0;
      end else if (adv_s) begin
        adv_idx_r <= adv_idx_r + CW'(1);
      end else begin
        adv_idx_r <= adv_idx_r;
      end
    end
  end

  // Output beat flags: the first BPR advances only prime the conv's row lag.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_tvalid_r <= 1'b0;
      m_tuser_r  <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else if (adv_s) begin
      m_tvalid_r <= (adv_idx_r >= FIRST_OUT_IDX);
      m_tuser_r  <= (adv_idx_r == FIRST_OUT_IDX);
      m_tlast_r  <= (adv_idx_r == LAST_ADV_IDX);
    end else if (m_tready) begin
      m_tvalid_r <= 1'b0;
      m_tuser_r  <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
      m_tuser_r  <= m_tuser_r;
      m_tlast_r  <= m_tlast_r;
    end
  end

`ifdef CONV_CTRL_STATS_EN
  logic [31:0] frame_cnt_r;
  logic [31:0] stall_cnt_r;

  // Frame and stall statistics counters.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      frame_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (m_tvalid_r && m_tready && m_tlast_r) begin
        frame_cnt_r <= frame_cnt_r + 32'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (((state_r == ST_RUN) || (state_r == ST_FLUSH)) && !adv_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

  // The conv's output is registered, so m_tdata holds while the conv is stalled.
  assign s_tready     = ready_s;
  assign conv_inp     = inp_s;
  assign conv_stall   = ~adv_s;
  assign conv_aresetn = conv_aresetn_r;
  assign m_tdata      = conv_out;
  assign m_tvalid     = m_tvalid_r;
  assign m_tuser      = m_tuser_r;
  assign m_tlast      = m_tlast_r;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_stream_ctrl
//
// Self-checking bench for conv_stream_ctrl at IMAGE_DIM=32, PIXELS_PER_BEAT=16
// (BPR=2, BPF=64). A behavioural conv stands in for CONV_GAUSS. On each
// advance it applies a vertical [1 2 1]/4 filter per pixel and has a one-row
// lag. Expected output beats are computed directly from the stored input
// image with zero padding above and below.
// -----------------------------------------------------------------------------
module tb_conv_stream_ctrl;

  localparam int PPB = 16;
  localparam int PW  = 8;
  localparam int DIM = 32;
  localparam int DW  = PW * PPB;
  localparam int BPR = DIM / PPB;
  localparam int BPF = DIM * BPR;

  logic          clk;
  logic          areset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tuser;
  logic          s_tlast;
  logic [DW-1:0] conv_inp;
  logic          conv_stall;
  logic          conv_aresetn;
  logic [DW-1:0] conv_out;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tuser;
  logic          m_tlast;
  logic          frame_err;
`ifdef CONV_CTRL_STATS_EN
  logic [31:0]   frame_cnt;
  logic [31:0]   stall_cnt;
`endif

  int vecs;
  int errs;

  logic [DW-1:0] img [0:BPF-1];

  conv_stream_ctrl #(
    .PIXELS_PER_BEAT(PPB),
    .PIXEL_WIDTH    (PW),
    .IMAGE_DIM      (DIM)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .conv_inp    (conv_inp),
    .conv_stall  (conv_stall),
    .conv_aresetn(conv_aresetn),
    .conv_out    (conv_out),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .frame_err   (frame_err)
`ifdef CONV_CTRL_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural conv: a 2*BPR-beat line buffer plus a registered output.
  logic [DW-1:0] cm_line [0:2*BPR-1];

  function automatic logic [DW-1:0] conv_vert(input logic [DW-1:0] top,
                                              input logic [DW-1:0] mid,
                                              input logic [DW-1:0] bot);
    logic [DW-1:0] r;
    logic [PW+1:0] s;
    r = '0;
    for (int p = 0; p < PPB; p++) begin
      s = {2'b00, top[p*PW +: PW]} + {1'b0, mid[p*PW +: PW], 1'b0} + {2'b00, bot[p*PW +: PW]};
      r[p*PW +: PW] = s[PW+1:2];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!conv_aresetn) begin
      for (int i = 0; i < 2*BPR; i++) cm_line[i] <= '0;
      conv_out <= '0;
    end else if (!conv_stall) begin
      conv_out   <= conv_vert(cm_line[2*BPR-1], cm_line[BPR-1], conv_inp);
      cm_line[0] <= conv_inp;
      for (int i = 1; i < 2*BPR; i++) cm_line[i] <= cm_line[i-1];
    end
  end

  // Golden output beat k: rows above/below taken from the image, zero outside.
  function automatic logic [DW-1:0] gold_beat(input int k);
    logic [DW-1:0] r;
    int a, b, c;
    r = '0;
    for (int p = 0; p < PPB; p++) begin
      a = (k >= BPR) ? int'(img[k-BPR][p*PW +: PW]) : 0;
      b = int'(img[k][p*PW +: PW]);
      c = (k + BPR < BPF) ? int'(img[k+BPR][p*PW +: PW]) : 0;
      r[p*PW +: PW] = PW'((a + 2*b + c) / 4);
    end
    return r;
  endfunction

  // One frame: drive BPF beats, track handshakes, and check every output beat.
  task automatic run_frame(input int gap_pct, input int mr_mode,
                           input logic [BPF-1:0] gap_mask, input int tlast_err_beat,
                           input int abort_beat, input int exp_err, input bit chk_first);
    int beat, outk, advn, cyc, err_seen, sof_hs, third_cyc, first_cyc, budget;
    bit presenting, gapped, prev_hold, s_hs, m_hs, adv, aborted;
    logic [DW-1:0] inp_cap, md_cap;
    logic mu_cap, ml_cap;
    beat = 0; outk = 0; advn = 0; cyc = 0; err_seen = 0; sof_hs = 0;
    third_cyc = -1; first_cyc = -1; budget = 3000;
    presenting = 0; gapped = 0; prev_hold = 0; aborted = 0;
    md_cap = '0; mu_cap = 1'b0; ml_cap = 1'b0;
    for (int i = 0; i < BPF; i++) img[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    m_tready = 1'b1;
    while (outk < BPF && !aborted && budget > 0) begin
      @(negedge clk);
      if (frame_err === 1'b1) err_seen++;
      if (m_tvalid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (prev_hold) begin
        vecs++;
        if (m_tvalid !== 1'b1 || m_tdata !== md_cap || m_tuser !== mu_cap || m_tlast !== ml_cap) begin
          errs++;
          $display("FAIL hold_stable beat %0d: got v=%b u=%b l=%b d=%h, want v=1 u=%b l=%b d=%h",
                   outk, m_tvalid, m_tuser, m_tlast, m_tdata, mu_cap, ml_cap, md_cap);
        end
      end
      if (abort_beat >= 0 && beat == abort_beat) begin
        aborted = 1;
      end else begin
        if (!presenting && beat < BPF) begin
          if (gap_mask[beat] && !gapped) begin
            gapped = 1;
          end else if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            gapped = gapped;
          end else begin
            presenting = 1;
            gapped = 0;
          end
        end
        s_tvalid = presenting;
        s_tdata  = presenting ? img[beat] : '0;
        s_tuser  = presenting && (beat == 0);
        s_tlast  = presenting && ((beat == BPF-1) || (beat == tlast_err_beat));
        case (mr_mode)
          0:       m_tready = 1'b1;
          1:       m_tready = ~m_tready;
          default: m_tready = 1'($urandom_range(1));
        endcase
        #1;
        s_hs = s_tvalid && s_tready;
        m_hs = m_tvalid && m_tready;
        adv = !conv_stall;
        inp_cap = conv_inp;
        md_cap = m_tdata; mu_cap = m_tuser; ml_cap = m_tlast;
        prev_hold = m_tvalid && !m_tready;
        @(posedge clk);
        cyc++;
        budget--;
        if (s_hs) begin
          if (beat == 0 && sof_hs == 0) begin
            sof_hs = 1;
          end else begin
            vecs++;
            if (inp_cap !== img[beat]) begin
              errs++;
              $display("FAIL conv_inp_run beat %0d: got %h want %h", beat, inp_cap, img[beat]);
            end
            beat++;
            presenting = 0;
            if (beat == 3) third_cyc = cyc;
          end
        end
        if (adv) begin
          if (advn >= BPF) begin
            vecs++;
            if (inp_cap !== '0) begin
              errs++;
              $display("FAIL flush_zero adv %0d: got %h want 0", advn, inp_cap);
            end
          end
          advn++;
        end
        if (m_hs) begin
          vecs++;
          if (md_cap !== gold_beat(outk) || mu_cap !== (outk == 0) || ml_cap !== (outk == BPF-1)) begin
            errs++;
            $display("FAIL out_beat %0d: got u=%b l=%b d=%h want u=%b l=%b d=%h",
                     outk, mu_cap, ml_cap, md_cap, (outk == 0), (outk == BPF-1), gold_beat(outk));
          end
          outk++;
        end
      end
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    if (aborted) begin
      areset = 1'b1;
      #1;
      vecs++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || conv_stall !== 1'b1 ||
          conv_aresetn !== 1'b0 || s_tready !== 1'b0) begin
        errs++;
        $display("FAIL abort_reset: got v=%b l=%b st=%b rn=%b rdy=%b want 0 0 1 0 0",
                 m_tvalid, m_tlast, conv_stall, conv_aresetn, s_tready);
      end
      repeat (2) @(negedge clk);
      areset = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      vecs++;
      if (budget <= 0 || outk != BPF) begin
        errs++;
        $display("FAIL frame_outputs: got %0d beats want %0d (budget left %0d)", outk, BPF, budget);
      end
      vecs++;
      if (advn != BPF + BPR) begin
        errs++;
        $display("FAIL adv_count: got %0d want %0d", advn, BPF + BPR);
      end
      vecs++;
      if (err_seen != exp_err) begin
        errs++;
        $display("FAIL frame_err_count: got %0d want %0d", err_seen, exp_err);
      end
      if (chk_first) begin
        vecs++;
        if (first_cyc != third_cyc || third_cyc < 0) begin
          errs++;
          $display("FAIL first_out_latency: got cycle %0d want %0d", first_cyc, third_cyc);
        end
      end
      @(negedge clk);
      vecs++;
      if (s_tready !== 1'b1 || conv_aresetn !== 1'b0 || m_tvalid !== 1'b0) begin
        errs++;
        $display("FAIL back_to_idle: got rdy=%b rn=%b v=%b want 1 0 0", s_tready, conv_aresetn, m_tvalid);
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if (m_tvalid !== 1'b0 || conv_stall !== 1'b1 || conv_aresetn !== 1'b0 || s_tready !== 1'b0 ||
        m_tuser !== 1'b0 || m_tlast !== 1'b0 || frame_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: got v=%b st=%b rn=%b rdy=%b u=%b l=%b e=%b want 0 1 0 0 0 0 0",
               m_tvalid, conv_stall, conv_aresetn, s_tready, m_tuser, m_tlast, frame_err);
    end
    areset = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (s_tready !== 1'b1 || conv_aresetn !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: got rdy=%b rn=%b want 1 0", s_tready, conv_aresetn);
    end
  endtask

  task automatic test_streaming();
    run_frame(0, 0, '0, -1, -1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, '0, -1, -1, 0, 1'b1);
    run_frame(0, 0, '0, -1, -1, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int f = 0; f < 2; f++) run_frame(30, 1, '0, -1, -1, 0, 1'b0);
    for (int f = 0; f < 2; f++) run_frame(40, 2, '0, -1, -1, 0, 1'b0);
  endtask

  task automatic test_framing();
    @(negedge clk);
    s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = {4{$urandom()}};
    #1;
    vecs++;
    if (s_tready !== 1'b1) begin
      errs++;
      $display("FAIL idle_stray_ready: got %b want 1", s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    vecs++;
    if (frame_err !== 1'b1) begin
      errs++;
      $display("FAIL idle_stray_err: got %b want 1", frame_err);
    end
    @(negedge clk);
    vecs++;
    if (frame_err !== 1'b0 || s_tready !== 1'b1 || conv_aresetn !== 1'b0 || m_tvalid !== 1'b0) begin
      errs++;
      $display("FAIL idle_stray_state: got e=%b rdy=%b rn=%b v=%b want 0 1 0 0",
               frame_err, s_tready, conv_aresetn, m_tvalid);
    end
    run_frame(0, 0, '0, -1, -1, 0, 1'b0);
    run_frame(20, 2, '0, 40, -1, 1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    run_frame(10, 0, '0, -1, 30, 0, 1'b0);
    run_frame(0, 0, '0, -1, -1, 0, 1'b1);
  endtask

`ifdef CONV_CTRL_STATS_EN
  task automatic test_stats();
    logic [BPF-1:0] m1, m2;
    m1 = '0; m2 = '0;
    m1[10] = 1'b1; m1[40] = 1'b1;
    m2[5] = 1'b1; m2[20] = 1'b1; m2[50] = 1'b1;
    areset = 1'b1;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(0, 0, m1, -1, -1, 0, 1'b0);
    run_frame(0, 0, m2, -1, -1, 0, 1'b0);
    vecs++;
    if (frame_cnt !== 32'd2 || stall_cnt !== 32'd5) begin
      errs++;
      $display("FAIL stats: got frame_cnt=%0d stall_cnt=%0d want 2 5", frame_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_streaming();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_reset_midframe();
`ifdef CONV_CTRL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
